multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: ALUCW, default 4, alucontrol width; SHALL be >= 3, with codes zero-extended to ALUCW.
REQ-002 Parameter: EN_BNE, default 1; when 1 the block SHALL decode BNE, when 0 it SHALL treat BNE as illegal.
REQ-003 Port: clk  in  1  single clock, rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high.
REQ-005 Port: op  in  6  instruction opcode from the instruction register.
REQ-006 Port: funct  in  6  R-type function field.
REQ-007 Port: zero  in  1  ALU zero flag.
REQ-008 Port: memready  in  1  memory completes the current request this cycle.
REQ-009 Port: memreq  out  1  memory access request.
REQ-010 Port: memwrite  out  1  the access is a write.
REQ-011 Port: iord  out  1  address select: 0 = PC, 1 = ALUOut.
REQ-012 Port: irwrite  out  1  instruction register load.
REQ-013 Port: regdst, memtoreg, regwrite, alusrca  out  1 each  datapath selects and enables.
REQ-014 Port: alusrcb  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
REQ-015 Port: pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-016 Port: pcen  out  1  PC write enable.
REQ-017 Port: alucontrol  out  ALUCW  ALU operation.
REQ-018 Port: illop  out  1  one-cycle pulse on an illegal opcode or funct.

Function
REQ-019 The controller SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX; all outputs not listed for a state SHALL be 0.
REQ-020 Opcodes SHALL be: R 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, J 000010.
REQ-021 FETCH: memreq=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00, ALU add; irwrite=pcen=memready; the FSM stays in FETCH until memready=1, then goes to DECODE.
REQ-022 DECODE: alusrcb=11, ALU add; next state is LW/SW->MEMADR, R->RTYPEEX, BEQ/BNE->BEQEX, ADDI->ADDIEX, J->JEX; any other opcode SHALL pulse illop and return to FETCH.
REQ-023 MEMADR: alusrca=1, alusrcb=10, ALU add; next state is MEMRD for LW and MEMWR for SW.
REQ-024 MEMRD: memreq=1, iord=1; the FSM holds until memready=1, then goes to MEMWB.
REQ-025 MEMWB: regwrite=1, memtoreg=1, regdst=0; next state is FETCH.
REQ-026 MEMWR: memreq=1, memwrite=1, iord=1; the FSM holds until memready=1, then goes to FETCH.
REQ-027 RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct; next state is RTYPEWB.
REQ-028 Funct decode: 100000 add=0010, 100010 sub=0110, 100100 and=0000, 100101 or=0001, 101010 slt=0111.
REQ-029 An unknown funct in RTYPEEX SHALL pulse illop, suppress regwrite in RTYPEWB, and return to FETCH.
REQ-030 RTYPEWB: regwrite=1, regdst=1, memtoreg=0; next state is FETCH.
REQ-031 BEQEX: alusrca=1, alusrcb=00, ALU sub, pcsrc=01; pcen SHALL be zero for BEQ and ~zero for BNE; next state is FETCH.
REQ-032 ADDIEX: alusrca=1, alusrcb=10, ALU add; next state is ADDIWB.
REQ-033 ADDIWB: regwrite=1, regdst=0, memtoreg=0; next state is FETCH.
REQ-034 JEX: pcsrc=10, pcen=1; next state is FETCH.
REQ-035 op and funct SHALL be sampled only in DECODE and RTYPEEX; changes to them in other states SHALL have no effect.
REQ-036 memready SHALL be ignored in states that do not assert memreq.

Reset
REQ-037 While reset=1, the state SHALL be FETCH and every output SHALL be forced to 0, asynchronously.
REQ-038 After reset deasserts, the first clock edge SHALL see FETCH outputs; a mid-instruction reset SHALL abandon the instruction with no regwrite or pcen.

Verification
REQ-039 Reset, then release with memready=1 continuously and op=LW: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1 and memtoreg=1 only in MEMWB.
REQ-040 FETCH with memready=0 for 3 cycles, then 1: memreq=1 for all 4 cycles; irwrite and pcen assert only in the 4th cycle.
REQ-041 BEQ with zero=1, then BNE with zero=1: pcen=1 in BEQEX for BEQ, pcen=0 for BNE; with EN_BNE=0, BNE pulses illop in DECODE.
REQ-042 R-type with funct=101010: alucontrol=0111 in RTYPEEX, then regwrite=1 and regdst=1 in RTYPEWB; funct=111111 gives illop=1 and no regwrite.
REQ-043 SW with reset asserted in MEMWR: all outputs drop to 0 immediately and FETCH follows release; op=111111 gives illop in DECODE, then FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore-style control FSM for a multicycle MIPS-subset datapath
//                (LW, SW, R-type, BEQ, BNE, ADDI, J) with a handshaked memory
//                and an illegal-instruction pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_controller #(
    parameter int ALUCW  = 4,
    parameter bit EN_BNE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             memready,
    output logic             memreq,
    output logic             memwrite,
    output logic             iord,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic             pcen,
    output logic [ALUCW-1:0] alucontrol,
    output logic             illop
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [ALUCW-1:0] ALU_AND = ALUCW'(3'b000);
    localparam logic [ALUCW-1:0] ALU_OR  = ALUCW'(3'b001);
    localparam logic [ALUCW-1:0] ALU_ADD = ALUCW'(3'b010);
    localparam logic [ALUCW-1:0] ALU_SUB = ALUCW'(3'b110);
    localparam logic [ALUCW-1:0] ALU_SLT = ALUCW'(3'b111);

    state_t           state, next_state;
    // Instruction attributes captured in DECODE so later states never look at op.
    logic             is_sw, next_is_sw;
    logic             is_bne, next_is_bne;
    // Captured in RTYPEEX so the write-back can be cancelled for a bad funct.
    logic             funct_bad, next_funct_bad;
    logic [ALUCW-1:0] funct_alu;
    logic             funct_ok;

    // State register and captured instruction attributes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            is_sw     <= 1'b0;
            is_bne    <= 1'b0;
            funct_bad <= 1'b0;
        end else begin
            state     <= next_state;
            is_sw     <= next_is_sw;
            is_bne    <= next_is_bne;
            funct_bad <= next_funct_bad;
        end
    end

    // R-type function field to ALU operation; unknown functs yield code 0.
    always_comb begin
        funct_alu = '0;
        funct_ok  = 1'b1;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Next-state and per-state outputs; reset forces every output low at once.
    always_comb begin
        next_state     = state;
        next_is_sw     = is_sw;
        next_is_bne    = is_bne;
        next_funct_bad = funct_bad;
        memreq         = 1'b0;
        memwrite       = 1'b0;
        iord           = 1'b0;
        irwrite        = 1'b0;
        regdst         = 1'b0;
        memtoreg       = 1'b0;
        regwrite       = 1'b0;
        alusrca        = 1'b0;
        alusrcb        = 2'b00;
        pcsrc          = 2'b00;
        pcen           = 1'b0;
        alucontrol     = '0;
        illop          = 1'b0;

        case (state)
            FETCH: begin
                memreq     = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                irwrite    = memready;
                pcen       = memready;
                if (memready) next_state = DECODE;
            end
            DECODE: begin
                alusrcb     = 2'b11;
                alucontrol  = ALU_ADD;
                next_is_sw  = (op == OP_SW);
                next_is_bne = (op == OP_BNE);
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_BNE: begin
                        if (EN_BNE) begin
                            next_state = BEQEX;
                        end else begin
                            illop      = 1'b1;
                            next_state = FETCH;
                        end
                    end
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JEX;
                    default: begin
                        illop      = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                next_state = is_sw ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memreq = 1'b1;
                iord   = 1'b1;
                if (memready) next_state = MEMWB;
            end
            MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                memreq   = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
                if (memready) next_state = FETCH;
            end
            RTYPEEX: begin
                alusrca        = 1'b1;
                alucontrol     = funct_alu;
                illop          = ~funct_ok;
                next_funct_bad = ~funct_ok;
                next_state     = RTYPEWB;
            end
            RTYPEWB: begin
                regwrite   = ~funct_bad;
                regdst     = 1'b1;
                next_state = FETCH;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = is_bne ? ~zero : zero;
                next_state = FETCH;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                next_state = FETCH;
            end
            JEX: begin
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase

        if (reset) begin
            memreq     = 1'b0;
            memwrite   = 1'b0;
            iord       = 1'b0;
            irwrite    = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            pcsrc      = 2'b00;
            pcen       = 1'b0;
            alucontrol = '0;
            illop      = 1'b0;
            next_state = FETCH;
        end
    end

endmodule
`default_nettype wire
